// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
//   Bundles the pc_sequencer status inputs and its PC-mux and memory-read
//   controls.
//   slave  : the sequencer view. It receives decoder, execution-unit, memory
//            and interrupt status, and drives MPC, pc_we, ifetch, vec_rd,
//            vec_addr and irq_ack.
//   master : the surrounding core view. It drives the status signals and
//            receives the controls.
interface pc_sequencer_if;
   logic        mem_rdy;
   logic        ir_valid;
   logic [1:0]  ext_words;
   logic        exec_done;
   logic        is_jump;
   logic        jump_taken;
   logic        is_pc_dst;
   logic        irq_req;
   logic [15:0] irq_vec;
   logic [2:0]  MPC;
   logic        pc_we;
   logic        ifetch;
   logic        vec_rd;
   logic [15:0] vec_addr;
   logic        irq_ack;

   modport slave (
      input  mem_rdy, ir_valid, ext_words, exec_done, is_jump, jump_taken,
             is_pc_dst, irq_req, irq_vec,
      output MPC, pc_we, ifetch, vec_rd, vec_addr, irq_ack
   );

   modport master (
      output mem_rdy, ir_valid, ext_words, exec_done, is_jump, jump_taken,
             is_pc_dst, irq_req, irq_vec,
      input  MPC, pc_we, ifetch, vec_rd, vec_addr, irq_ack
   );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Steps each MSP430 instruction through its phases: reset-vector load,
//   opcode fetch, decode, extension-word fetches, execute, and an optional
//   interrupt-vector load. In every phase it selects the mux_pc source,
//   strobes the PC write enable, and issues the fetch and vector-read strobes.
//   Ports:
//     clk   : core clock. All state changes happen on the rising edge.
//     rst_n : asynchronous active-low reset. It returns the sequencer to RST_VEC.
//     bus   : pc_sequencer_if.slave. It carries the status inputs and the
//             MPC, pc_we, ifetch, vec_rd, vec_addr and irq_ack outputs.
//   Only the state and the extension-word counter are registered. The outputs
//   are decoded combinationally from the state and the current status inputs,
//   because pc_we and irq_ack must follow mem_rdy in the same cycle.
module pc_sequencer (
   input  logic                  clk,
   input  logic                  rst_n,
   pc_sequencer_if.slave         bus
);

   typedef enum logic [2:0] {
      RST_VEC = 3'd0,
      FETCH   = 3'd1,
      DECODE  = 3'd2,
      EXT     = 3'd3,
      EXEC    = 3'd4,
      IRQ_VEC = 3'd5
   } state_t;

   localparam logic [2:0]  MPC_HOLD  = 3'd0;
   localparam logic [2:0]  MPC_INC2  = 3'd1;
   localparam logic [2:0]  MPC_MDB   = 3'd2;
   localparam logic [2:0]  MPC_CALC  = 3'd3;
   localparam logic [15:0] RESET_VEC = 16'hFFFE;

   state_t      state_r;
   state_t      state_nxt_s;
   logic [1:0]  ext_cnt_r;
   logic [1:0]  ext_cnt_nxt_s;

   logic [2:0]  mpc_s;
   logic        pc_we_s;
   logic        ifetch_s;
   logic        vec_rd_s;
   logic [15:0] vec_addr_s;
   logic        irq_ack_s;
   logic        pc_load_s;

   // PC is reloaded from CALC_OUT on a taken jump or on an explicit PC destination.
   assign pc_load_s = (bus.is_jump & bus.jump_taken) | bus.is_pc_dst;

   // State and extension-word counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= RST_VEC;
         ext_cnt_r <= 2'd0;
      end else begin
         state_r   <= state_nxt_s;
         ext_cnt_r <= ext_cnt_nxt_s;
      end
   end

   // Next-state and output decode.
   always_comb begin
      state_nxt_s   = state_r;
      ext_cnt_nxt_s = ext_cnt_r;
      mpc_s         = MPC_HOLD;
      pc_we_s       = 1'b0;
      ifetch_s      = 1'b0;
      vec_rd_s      = 1'b0;
      vec_addr_s    = RESET_VEC;
      irq_ack_s     = 1'b0;

      case (state_r)
         RST_VEC: begin
            vec_rd_s = 1'b1;
            mpc_s    = MPC_MDB;
            pc_we_s  = bus.mem_rdy;
            if (bus.mem_rdy) begin
               state_nxt_s = FETCH;
            end else begin
               state_nxt_s = RST_VEC;
            end
         end

         FETCH: begin
            ifetch_s = 1'b1;
            mpc_s    = MPC_INC2;
            pc_we_s  = bus.mem_rdy;
            if (bus.mem_rdy) begin
               state_nxt_s = DECODE;
            end else begin
               state_nxt_s = FETCH;
            end
         end

         DECODE: begin
            if (bus.ir_valid) begin
               if (bus.ext_words == 2'd0) begin
                  state_nxt_s = EXEC;
               end else begin
                  // A count of three cannot occur on MSP430, so it is clamped to two.
                  if (bus.ext_words == 2'd3) begin
                     ext_cnt_nxt_s = 2'd2;
                  end else begin
                     ext_cnt_nxt_s = bus.ext_words;
                  end
                  state_nxt_s = EXT;
               end
            end else begin
               state_nxt_s = DECODE;
            end
         end

         EXT: begin
            ifetch_s = 1'b1;
            mpc_s    = MPC_INC2;
            pc_we_s  = bus.mem_rdy;
            if (bus.mem_rdy) begin
               ext_cnt_nxt_s = ext_cnt_r - 2'd1;
               // A zero count cannot occur here. If it does, the sequencer
               // leaves EXT rather than wrapping the counter.
               if (ext_cnt_r <= 2'd1) begin
                  ext_cnt_nxt_s = 2'd0;
                  state_nxt_s   = EXEC;
               end else begin
                  state_nxt_s   = EXT;
               end
            end else begin
               state_nxt_s = EXT;
            end
         end

         EXEC: begin
            if (bus.exec_done) begin
               if (pc_load_s) begin
                  mpc_s   = MPC_CALC;
                  pc_we_s = 1'b1;
               end else begin
                  mpc_s   = MPC_HOLD;
               end
               // The vector load follows the CALC_OUT load, so the vector
               // wins when both happen.
               if (bus.irq_req) begin
                  state_nxt_s = IRQ_VEC;
               end else begin
                  state_nxt_s = FETCH;
               end
            end else begin
               state_nxt_s = EXEC;
            end
         end

         IRQ_VEC: begin
            vec_rd_s   = 1'b1;
            vec_addr_s = bus.irq_vec;
            mpc_s      = MPC_MDB;
            pc_we_s    = bus.mem_rdy;
            irq_ack_s  = bus.mem_rdy;
            if (bus.mem_rdy) begin
               state_nxt_s = FETCH;
            end else begin
               state_nxt_s = IRQ_VEC;
            end
         end

         default: begin
            state_nxt_s   = RST_VEC;
            ext_cnt_nxt_s = 2'd0;
         end
      endcase
   end

   assign bus.MPC      = mpc_s;
   assign bus.pc_we    = pc_we_s;
   assign bus.ifetch   = ifetch_s;
   assign bus.vec_rd   = vec_rd_s;
   assign bus.vec_addr = vec_addr_s;
   assign bus.irq_ack  = irq_ack_s;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//   Directed test for pc_sequencer. Each cycle the bench drives the status
//   inputs, lets the combinational outputs settle, and compares the packed
//   output word {MPC, pc_we, ifetch, vec_rd, irq_ack, vec_addr} with a
//   hand-computed constant.
module tb_pc_sequencer;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   pc_sequencer_if bus ();

   pc_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [22:0] pk(input logic [2:0] mpc, input logic we,
                                      input logic ifc, input logic vr,
                                      input logic ack, input logic [15:0] addr);
      return {mpc, we, ifc, vr, ack, addr};
   endfunction

   logic [22:0] O_RSTV_W, O_RSTV_R, O_FETCH_W, O_FETCH_R, O_IDLE, O_CALC, O_IRQ_W, O_IRQ_R;

   task automatic check_eq(input string tag, input logic [22:0] obs, input logic [22:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Settle the combinational outputs, then compare them.
   task automatic chk(input string tag, input logic [22:0] exp);
      #1;
      check_eq(tag, {bus.MPC, bus.pc_we, bus.ifetch, bus.vec_rd, bus.irq_ack, bus.vec_addr}, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input string tag, input logic [22:0] exp);
      chk(tag, exp);
      tick();
   endtask

   task automatic clr_exec();
      bus.exec_done  = 1'b0;
      bus.is_jump    = 1'b0;
      bus.jump_taken = 1'b0;
      bus.is_pc_dst  = 1'b0;
   endtask

   // Runs FETCH with zero wait, then DECODE with the given extension-word count.
   task automatic fetch_decode(input string tag, input logic [1:0] ext);
      bus.mem_rdy = 1'b1;
      step({tag, "_fetch"}, O_FETCH_R);
      bus.mem_rdy   = 1'b0;
      bus.ir_valid  = 1'b1;
      bus.ext_words = ext;
      step({tag, "_decode"}, O_IDLE);
      bus.ir_valid  = 1'b0;
      bus.ext_words = 2'd0;
   endtask

   // Fetches two extension words, each preceded by two wait cycles.
   task automatic ext_two_waited(input string tag);
      for (int w = 0; w < 2; w++) begin
         bus.mem_rdy = 1'b0;
         step({tag, "_stall"}, O_FETCH_W);
         step({tag, "_stall"}, O_FETCH_W);
         bus.mem_rdy = 1'b1;
         step({tag, "_word"}, O_FETCH_R);
      end
      bus.mem_rdy = 1'b0;
   endtask

   initial begin
      O_RSTV_W  = pk(3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFE);
      O_RSTV_R  = pk(3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFE);
      O_FETCH_W = pk(3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFE);
      O_FETCH_R = pk(3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFE);
      O_IDLE    = pk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFE);
      O_CALC    = pk(3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFE);
      O_IRQ_W   = pk(3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 16'hFFF2);
      O_IRQ_R   = pk(3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 16'hFFF2);
      n_checks = 0;
      n_fail   = 0;

      rst_n         = 1'b0;
      bus.mem_rdy   = 1'b0;
      bus.ir_valid  = 1'b0;
      bus.ext_words = 2'd0;
      bus.irq_req   = 1'b0;
      bus.irq_vec   = 16'hFFF2;
      clr_exec();
      repeat (3) @(posedge clk);
      #1;
      chk("reset", O_RSTV_W);

      // Release reset. The reset vector stalls one cycle, then loads.
      rst_n = 1'b1;
      tick();
      step("rstvec_stall", O_RSTV_W);
      bus.mem_rdy = 1'b1;
      step("rstvec_load", O_RSTV_R);

      // Single-word instruction with no wait states. exec_done and
      // is_pc_dst are raised in DECODE to confirm they are ignored there.
      step("i1_fetch", O_FETCH_R);
      bus.mem_rdy   = 1'b0;
      bus.exec_done = 1'b1;
      bus.is_pc_dst = 1'b1;
      step("i1_decode_wait", O_IDLE);
      clr_exec();
      bus.ir_valid  = 1'b1;
      step("i1_decode", O_IDLE);
      bus.ir_valid  = 1'b0;
      step("i1_exec_wait", O_IDLE);
      bus.exec_done = 1'b1;
      step("i1_exec_nojump", O_IDLE);
      clr_exec();

      // Two extension words with stalls, then a taken jump.
      fetch_decode("i2", 2'd2);
      ext_two_waited("i2_ext");
      step("i2_exec_wait", O_IDLE);
      bus.exec_done  = 1'b1;
      bus.is_jump    = 1'b1;
      bus.jump_taken = 1'b1;
      step("i2_jump_taken", O_CALC);
      clr_exec();

      // ext_words=3 is clamped to two words. The jump is not taken.
      fetch_decode("i3", 2'd3);
      ext_two_waited("i3_ext");
      bus.exec_done  = 1'b1;
      bus.is_jump    = 1'b1;
      bus.jump_taken = 1'b0;
      step("i3_jump_not_taken", O_IDLE);
      clr_exec();

      // An interrupt request coincides with a taken jump.
      // irq_req is already high during fetch and decode to show it is ignored there.
      bus.irq_req = 1'b1;
      fetch_decode("i4", 2'd0);
      step("i4_exec_irq_nodone", O_IDLE);
      bus.exec_done  = 1'b1;
      bus.is_jump    = 1'b1;
      bus.jump_taken = 1'b1;
      step("i4_jump_irq", O_CALC);
      clr_exec();
      step("i4_irqvec_stall", O_IRQ_W);
      bus.mem_rdy = 1'b1;
      step("i4_irqvec_load", O_IRQ_R);
      bus.irq_req = 1'b0;

      // PC-destination load without a jump.
      fetch_decode("i5", 2'd0);
      bus.exec_done = 1'b1;
      bus.is_pc_dst = 1'b1;
      step("i5_pc_dst", O_CALC);
      clr_exec();

      // A single extension word, then EXEC.
      fetch_decode("i6", 2'd1);
      bus.mem_rdy = 1'b1;
      step("i6_ext", O_FETCH_R);
      bus.mem_rdy = 1'b0;
      step("i6_exec_wait", O_IDLE);
      bus.exec_done = 1'b1;
      step("i6_exec", O_IDLE);
      clr_exec();

      // Reset is asserted in EXT while one word remains.
      fetch_decode("i7", 2'd2);
      bus.mem_rdy = 1'b1;
      step("i7_ext1", O_FETCH_R);
      bus.mem_rdy = 1'b0;
      chk("i7_ext_stall", O_FETCH_W);
      rst_n = 1'b0;
      chk("i7_rst_async", O_RSTV_W);
      tick();
      step("i7_rst_hold", O_RSTV_W);
      rst_n = 1'b1;
      bus.mem_rdy = 1'b1;
      step("i7_rstvec_load", O_RSTV_R);
      step("i7_refetch", O_FETCH_R);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Sequencer that drives the select and write enable of the program-counter input multiplexer (`mux_pc`) in the MSP430 core. It walks each instruction through the following phases:

- reset-vector load
- opcode fetch
- extension-word fetches
- execute
- optional interrupt-vector load

In each phase it chooses whether the PC holds, advances by 2, loads from MDB, or loads from CALC_OUT. It sits between the instruction decoder/execution unit and `mux_pc`/PC register, and also issues the memory-read strobes for fetches and vector reads.

## Interface
- No parameters.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  core clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `mem_rdy`  in  1  MDB holds valid read data this cycle.
- `ir_valid`  in  1  decoder has latched the opcode word.
- `ext_words`  in  2  extension-word count of the decoded instruction; sampled with `ir_valid`.
- `exec_done`  in  1  execution finished; CALC_OUT is valid this cycle.
- `is_jump`  in  1  instruction is a jump; sampled with `exec_done`.
- `jump_taken`  in  1  jump condition true; sampled with `exec_done`.
- `is_pc_dst`  in  1  instruction writes PC from CALC_OUT; sampled with `exec_done`.
- `irq_req`  in  1  pending maskable or NMI request.
- `irq_vec`  in  16  vector address for the pending interrupt.
- `MPC`  out  3  `mux_pc` select:
  - 0 = hold reg_PC_out
  - 1 = PC+2
  - 2 = MDB
  - 3 = CALC_OUT
  - codes 4–7 are never driven.
- `pc_we`  out  1  PC register load enable.
- `ifetch`  out  1  read at address PC (opcode or extension word).
- `vec_rd`  out  1  read at `vec_addr`.
- `vec_addr`  out  16  vector address.
- `irq_ack`  out  1  one-cycle pulse when the interrupt vector is loaded.

## Operation
- States: RST_VEC, FETCH, DECODE, EXT, EXEC, IRQ_VEC.
- State and ext counter are flops; outputs are decoded from the current state plus the listed inputs.
- **RST_VEC**
  - Outputs: `vec_rd`=1, `vec_addr`=16'hFFFE, `MPC`=2, `pc_we`=`mem_rdy`.
  - Transition: `mem_rdy` → FETCH.
- **FETCH**
  - Outputs: `ifetch`=1, `MPC`=1, `pc_we`=`mem_rdy`.
  - Transition: `mem_rdy` → DECODE.
- **DECODE**
  - Outputs: `MPC`=0, `pc_we`=0.
  - On `ir_valid`:
    - `ext_words`=0 → EXEC.
    - Otherwise load `ext_cnt`=min(`ext_words`,2) → EXT.
  - `ext_words`=3 is clamped to 2.
- **EXT**
  - Outputs: `ifetch`=1, `MPC`=1, `pc_we`=`mem_rdy`.
  - On `mem_rdy`: `ext_cnt` decrements.
  - `mem_rdy` while `ext_cnt`=1 → EXEC.
- **EXEC**
  - Outputs: `MPC`=0, `pc_we`=0 until `exec_done`.
  - When `exec_done` and (`is_jump`&`jump_taken` | `is_pc_dst`): `MPC`=3, `pc_we`=1.
  - Next state after `exec_done`: IRQ_VEC if `irq_req`=1, else FETCH.
- **IRQ_VEC**
  - Outputs: `vec_rd`=1, `vec_addr`=`irq_vec`, `MPC`=2, `pc_we`=`mem_rdy`, `irq_ack`=`mem_rdy`.
  - Transition: `mem_rdy` → FETCH.
  - PC/SR stacking belongs to the execution unit, not this block.
- In any state other than IRQ_VEC, `vec_addr` is 16'hFFFE.
- Only the outputs listed above are ever asserted; all others are 0.

## Timing
- Reset (async, while `rst_n`=0):
  - state = RST_VEC, `ext_cnt`=0.
  - Outputs: `vec_rd`=1, `vec_addr`=16'hFFFE, `MPC`=2, `pc_we`=0 (`mem_rdy` low), `ifetch`=0, `irq_ack`=0.
- Reset asserted mid-instruction: immediate return to RST_VEC. Any partial EXT count is discarded.
- Memory latency:
  - Every memory state stalls indefinitely while `mem_rdy`=0, with `MPC` held and `pc_we`=0.
  - The zero-wait minimum is 1 cycle per word.
- Minimum instruction length (zero wait, 0 ext words, `exec_done` on the first EXEC cycle): 3 cycles (FETCH, DECODE, EXEC).
- Each extension word adds 1 cycle.
- Inputs are sampled only in the state and on the strobe stated above; `irq_req` is ignored outside EXEC.
- Jump taken and `irq_req` in the same `exec_done` cycle:
  - PC is loaded from CALC_OUT that cycle.
  - Next state is IRQ_VEC, so the vector overrides the PC on the following `mem_rdy`.
- `ir_valid` and `exec_done` outside their states have no effect.

## Test plan
- **Reset vector:** release `rst_n`; `mem_rdy`=1 with MDB=16'h4400 → 1 cycle with `MPC`=2, `pc_we`=1, `vec_addr`=FFFE; then FETCH with `MPC`=1, `ifetch`=1.
- **Zero-wait single-word instruction:** `ir_valid` with `ext_words`=0, `exec_done` with no jump → sequence FETCH, DECODE, EXEC, FETCH.
  - `pc_we` high exactly once (the FETCH cycle) per instruction.
- **Two extension words, with waits:** `ext_words`=2 and `mem_rdy` low 2 cycles before each word → two `MPC`=1/`pc_we` pulses in EXT, `MPC` held during stalls, then EXEC.
  - Repeat with `ext_words`=3 → identical behaviour (clamped to 2).
- **Jump:** `exec_done` with `is_jump`=1, `jump_taken`=1, CALC_OUT=16'hA000 → `MPC`=3, `pc_we`=1 that cycle.
  - Repeat with `jump_taken`=0 → `pc_we`=0.
- **Interrupt coincident with jump:** `irq_req`=1, `irq_vec`=16'hFFF2, coincident jump → CALC_OUT load, then IRQ_VEC with `vec_addr`=FFF2, `MPC`=2, `irq_ack` pulse of 1 cycle, then FETCH.
- **Reset during EXT:** `rst_n` asserted in EXT with `ext_cnt`=1 → next cycle RST_VEC outputs, and no further `ifetch`.
